// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative multiply/divide sequencer.
package muldiv_pkg;
  localparam int DEF_WIDTH = 32;

  typedef enum logic [1:0] {
    OP_MULTU = 2'b00,
    OP_MULT  = 2'b01,
    OP_DIVU  = 2'b10,
    OP_DIV   = 2'b11
  } op_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PREP,
    S_RUN,
    S_FIX,
    S_DONE
  } state_e;
endpackage

// File: rtl/muldiv_step.sv
// One combinational iteration: LSB-first shift-add (multiply) or restoring
// shift-subtract (divide) on a {high, low} accumulator.
module muldiv_step #(
  parameter int WIDTH = 32
) (
  input  logic               is_div,
  input  logic [2*WIDTH-1:0] acc_i,
  input  logic [WIDTH-1:0]   opnd_i,
  output logic [2*WIDTH-1:0] acc_o
);
  logic [WIDTH:0] sum;
  logic [WIDTH:0] rem_sh;
  logic [WIDTH:0] trial;

  always_comb begin
    sum    = {1'b0, acc_i[2*WIDTH-1:WIDTH]} + (acc_i[0] ? {1'b0, opnd_i} : '0);
    rem_sh = {acc_i[2*WIDTH-1:WIDTH], acc_i[WIDTH-1]};
    trial  = rem_sh - {1'b0, opnd_i};
    if (is_div) begin
      // trial[WIDTH] set means the subtraction went negative: restore
      acc_o = {(trial[WIDTH] ? rem_sh[WIDTH-1:0] : trial[WIDTH-1:0]),
               acc_i[WIDTH-2:0], ~trial[WIDTH]};
    end else begin
      acc_o = {sum, acc_i[WIDTH-1:1]};
    end
  end
endmodule

// File: rtl/muldiv_sequencer.sv
// Multi-cycle MULT/MULTU/DIV/DIVU controller holding HI/LO and requesting
// a pipeline stall while an operation is in flight.
module muldiv_sequencer
  import muldiv_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] operando_1,
  input  logic [WIDTH-1:0] operando_2,
  input  logic             flush,
  output logic             stall_out,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi_out,
  output logic [WIDTH-1:0] lo_out
);
  localparam int CW = $clog2(WIDTH);

  state_e             state_q, state_d;
  op_e                op_q, op_d;
  logic [WIDTH-1:0]   a_q, a_d, b_q, b_d;
  logic [WIDTH-1:0]   opnd_q, opnd_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               neg_res_q, neg_res_d, neg_rem_q, neg_rem_d;
  logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
  logic               dbz_q, dbz_d;

  logic               is_div, is_signed;
  logic               sign_a, sign_b;
  logic [WIDTH-1:0]   a_abs, b_abs;
  logic [2*WIDTH-1:0] acc_step, prod;

  assign is_div    = op_q[1];
  assign is_signed = op_q[0];

  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .is_div (is_div),
    .acc_i  (acc_q),
    .opnd_i (opnd_q),
    .acc_o  (acc_step)
  );

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    a_d       = a_q;
    b_d       = b_q;
    opnd_d    = opnd_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    dbz_d     = dbz_q;

    sign_a = is_signed & a_q[WIDTH-1];
    sign_b = is_signed & b_q[WIDTH-1];
    a_abs  = sign_a ? -a_q : a_q;
    b_abs  = sign_b ? -b_q : b_q;
    prod   = neg_res_q ? -acc_q : acc_q;

    unique case (state_q)
      S_IDLE: begin
        if (start && !flush) begin
          op_d    = op_e'(op);
          a_d     = operando_1;
          b_d     = operando_2;
          dbz_d   = 1'b0;
          state_d = S_PREP;
        end
      end
      S_PREP: begin
        neg_res_d = sign_a ^ sign_b;
        neg_rem_d = sign_a;
        cnt_d     = '0;
        if (flush) begin
          state_d = S_IDLE;
        end else if (is_div && b_q == '0) begin
          hi_d    = a_q;
          lo_d    = '1;
          dbz_d   = 1'b1;
          state_d = S_DONE;
        end else begin
          // Multiply: add |op1| per multiplier bit; divide: subtract |op2|
          opnd_d  = is_div ? b_abs : a_abs;
          acc_d   = {{WIDTH{1'b0}}, (is_div ? a_abs : b_abs)};
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        acc_d = acc_step;
        cnt_d = cnt_q + 1'b1;
        if (flush)                           state_d = S_IDLE;
        else if (cnt_q == CW'(WIDTH - 1))    state_d = S_FIX;
      end
      S_FIX: begin
        if (flush) begin
          state_d = S_IDLE;
        end else begin
          if (is_div) begin
            lo_d = neg_res_q ? -acc_q[WIDTH-1:0]       : acc_q[WIDTH-1:0];
            hi_d = neg_rem_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
          end else begin
            hi_d = prod[2*WIDTH-1:WIDTH];
            lo_d = prod[WIDTH-1:0];
          end
          state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      op_q      <= OP_MULTU;
      a_q       <= '0;
      b_q       <= '0;
      opnd_q    <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      dbz_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      a_q       <= a_d;
      b_q       <= b_d;
      opnd_q    <= opnd_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      dbz_q     <= dbz_d;
    end
  end

  // Stall is combinational on start so the issuing instruction freezes in place
  assign stall_out   = (start && state_q == S_IDLE && !flush) ||
                       (!flush && (state_q == S_PREP || state_q == S_RUN || state_q == S_FIX));
  assign busy        = (state_q != S_IDLE);
  assign done        = (state_q == S_DONE) && !flush;
  assign div_by_zero = dbz_q;
  assign hi_out      = hi_q;
  assign lo_out      = lo_q;
endmodule

// File: tb/tb_muldiv_sequencer.sv
// Self-checking bench for muldiv_sequencer against an arithmetic reference model.
module tb_muldiv_sequencer;
  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [31:0] operando_1 = '0, operando_2 = '0;
  logic        flush = 1'b0;
  logic        stall_out, busy, done, div_by_zero;
  logic [31:0] hi_out, lo_out;

  int checks = 0;
  int errors = 0;

  muldiv_sequencer #(.WIDTH(32)) dut (
    .clock(clock), .reset_n(reset_n), .start(start), .op(op),
    .operando_1(operando_1), .operando_2(operando_2), .flush(flush),
    .stall_out(stall_out), .busy(busy), .done(done), .div_by_zero(div_by_zero),
    .hi_out(hi_out), .lo_out(lo_out)
  );

  always #5 clock = ~clock;

  // Reference: plain integer arithmetic on 64-bit values
  task automatic model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] hi, output logic [31:0] lo,
                       output logic dbz, output int lat);
    longint sa, sb, q, r;
    logic [63:0] p;
    dbz = 1'b0; lat = 35;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    hi = '0; lo = '0;
    case (o)
      2'b00: begin p = {32'h0, a} * {32'h0, b}; hi = p[63:32]; lo = p[31:0]; end
      2'b01: begin p = sa * sb; hi = p[63:32]; lo = p[31:0]; end
      default: begin
        if (b == 0) begin
          hi = a; lo = 32'hFFFF_FFFF; dbz = 1'b1; lat = 2;
        end else if (o == 2'b10) begin
          lo = a / b; hi = a % b;
        end else begin
          q = sa / sb; r = sa % sb;
          lo = q[31:0]; hi = r[31:0];
        end
      end
    endcase
  endtask

  // Issue one op in cycle 0 and wait (bounded) for done
  task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] hi, output logic [31:0] lo,
                        output logic dbz, output int lat, output int stall_bad);
    @(negedge clock);
    start = 1'b1; op = o; operando_1 = a; operando_2 = b;
    #1 stall_bad = (stall_out !== 1'b1) ? 1 : 0;
    lat = -1;
    for (int k = 1; k <= 40 && lat < 0; k++) begin
      @(negedge clock);
      start = 1'b0;
      #1;
      if (done === 1'b1) begin
        lat = k;
        if (stall_out !== 1'b0) stall_bad++;
      end else if (stall_out !== 1'b1) begin
        stall_bad++;
      end
    end
    hi = hi_out; lo = lo_out; dbz = div_by_zero;
  endtask

  task automatic check_op(input string name, input logic [1:0] o,
                          input logic [31:0] a, input logic [31:0] b);
    logic [31:0] ehi, elo, hi, lo;
    logic edbz, dbz;
    int elat, lat, sb;
    model(o, a, b, ehi, elo, edbz, elat);
    run_op(o, a, b, hi, lo, dbz, lat, sb);
    checks++;
    if (lat !== elat) begin errors++; $display("FAIL %s latency: got %0d want %0d", name, lat, elat); end
    checks++;
    if (hi !== ehi || lo !== elo) begin
      errors++; $display("FAIL %s result op=%0d a=%h b=%h: got hi=%h lo=%h want hi=%h lo=%h",
                         name, o, a, b, hi, lo, ehi, elo);
    end
    checks++;
    if (dbz !== edbz) begin errors++; $display("FAIL %s div_by_zero: got %b want %b", name, dbz, edbz); end
    checks++;
    if (sb !== 0) begin errors++; $display("FAIL %s stall_out profile: %0d bad cycles want 0", name, sb); end
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if ({stall_out, busy, done, div_by_zero, hi_out, lo_out} !== '0) begin
      errors++; $display("FAIL reset outputs: got stall=%b busy=%b done=%b dbz=%b hi=%h lo=%h want all 0",
                         stall_out, busy, done, div_by_zero, hi_out, lo_out);
    end
    @(negedge clock); reset_n = 1'b1;
  endtask

  task automatic test_directed();
    check_op("multu_max", 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    check_op("mult_neg",  2'b01, 32'hFFFF_FFFD, 32'h7);
    check_op("div_neg",   2'b11, 32'hFFFF_FFF9, 32'h2);
    check_op("div_ovf",   2'b11, 32'h8000_0000, 32'hFFFF_FFFF);
    check_op("mult_min",  2'b01, 32'h8000_0000, 32'h8000_0000);
    check_op("divu_big",  2'b10, 32'hFFFF_FFFF, 32'h1);
  endtask

  task automatic test_div_zero();
    check_op("divu_zero", 2'b10, 32'h5, 32'h0);
    check_op("div_zero",  2'b11, 32'h8000_0001, 32'h0);
    @(negedge clock);
    start = 1'b1; op = 2'b00; operando_1 = 32'd1; operando_2 = 32'd1;
    @(negedge clock);
    start = 1'b0;
    #1 checks++;
    if (div_by_zero !== 1'b0) begin errors++; $display("FAIL dbz_clear: got %b want 0", div_by_zero); end
    for (int k = 0; k < 40 && busy === 1'b1; k++) @(negedge clock);
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL dbz_clear_timeout: busy=%b want 0", busy); end
  endtask

  task automatic test_random();
    logic [1:0] o;
    logic [31:0] a, b;
    for (int i = 0; i < 20; i++) begin
      o = 2'($urandom_range(0, 3));
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 5))
        0: b = 32'h0;
        1: b = 32'($urandom_range(1, 9));
        2: a = 32'h8000_0000;
        default: ;
      endcase
      check_op("random", o, a, b);
    end
  endtask

  task automatic test_flush();
    logic [31:0] hi, lo;
    logic dbz;
    int lat, sb, seen;
    run_op(2'b00, 32'd2, 32'd3, hi, lo, dbz, lat, sb);
    checks++;
    if (hi !== 32'd0 || lo !== 32'd6) begin errors++; $display("FAIL flush_pre: got %h/%h want 0/6", hi, lo); end
    @(negedge clock);
    start = 1'b1; op = 2'b10; operando_1 = 32'd100; operando_2 = 32'd7;
    for (int k = 1; k <= 10; k++) begin @(negedge clock); start = 1'b0; end
    flush = 1'b1;
    #1 checks++;
    if (stall_out !== 1'b0) begin errors++; $display("FAIL flush_stall: got %b want 0", stall_out); end
    @(negedge clock);
    flush = 1'b0;
    #1 checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL flush_busy: got %b want 0", busy); end
    seen = 0;
    for (int k = 0; k < 40; k++) begin @(negedge clock); if (done === 1'b1) seen++; end
    checks++;
    if (seen != 0) begin errors++; $display("FAIL flush_done: got %0d pulses want 0", seen); end
    checks++;
    if (hi_out !== 32'd0 || lo_out !== 32'd6) begin
      errors++; $display("FAIL flush_hold: got %h/%h want 0/6", hi_out, lo_out);
    end
  endtask

  // start stays high through RUN and DONE with changing operands
  task automatic test_back_to_back();
    @(negedge clock);
    start = 1'b1; op = 2'b10; operando_1 = 32'd100; operando_2 = 32'd7;
    for (int k = 1; k <= 35; k++) begin
      @(negedge clock);
      operando_1 = $urandom; operando_2 = $urandom | 32'h1; op = 2'b01;
    end
    #1 checks++;
    if (done !== 1'b1 || stall_out !== 1'b0) begin
      errors++; $display("FAIL hold_done: got done=%b stall=%b want 1/0", done, stall_out);
    end
    checks++;
    if (hi_out !== 32'd2 || lo_out !== 32'd14) begin
      errors++; $display("FAIL hold_result: got %h/%h want 2/e", hi_out, lo_out);
    end
    @(negedge clock);
    start = 1'b0;
    @(negedge clock);
    #1 checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL hold_reaccept: busy=%b want 0", busy); end
  endtask

  task automatic test_async_reset();
    @(negedge clock);
    start = 1'b1; op = 2'b01; operando_1 = 32'hFFFF_FFFD; operando_2 = 32'd7;
    for (int k = 1; k <= 20; k++) begin @(negedge clock); start = 1'b0; end
    #2 reset_n = 1'b0;
    #1 checks++;
    if ({stall_out, busy, done, div_by_zero, hi_out, lo_out} !== '0) begin
      errors++; $display("FAIL async_reset: got stall=%b busy=%b done=%b dbz=%b hi=%h lo=%h want all 0",
                         stall_out, busy, done, div_by_zero, hi_out, lo_out);
    end
    @(negedge clock); reset_n = 1'b1;
    check_op("post_reset", 2'b00, 32'd4, 32'd5);
  endtask

  initial begin
    test_reset();
    test_directed();
    test_div_zero();
    test_random();
    test_flush();
    test_back_to_back();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
